// File: rtl/pc_fetch_if.sv
// Instruction-memory fetch channel: word request/ack handshake between the
// fetch front end (master) and instruction memory (slave).
interface pc_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, issues word fetches over the
// req/ack channel and holds the fetched instruction for IF/ID. A one-entry
// skid buffer catches a fetch that lands while the pipeline is stalled.
// Redirects follow MIPS delay-slot rules: the fetch already in flight when
// the branch arrives is delivered, the redirect steers the next address.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | post-reset, no request; moves to S_FETCH on the next edge
// S_FETCH | request raised at pc; waits for ack, then refills out or skid
// S_SKID  | out and skid both full; request dropped until out is consumed
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_address_i,
    pc_fetch_if.master        imem,
    output logic              if_valid_o,
    output logic [31:0]       if_pc_o,
    output logic [31:0]       if_inst_o
);

    localparam logic [31:0] RESET_PC_WORD = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t      state;
    logic        req_r;
    logic [31:0] pc;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;

    logic        transfer;
    logic        consume;
    logic        out_free;
    logic [31:0] target_word;
    logic [31:0] pc_after_fetch;

    // The address always comes straight from the PC register, so it is
    // stable for as long as the request is held.
    assign imem.req    = req_r;
    assign imem.addr   = pc;

    assign transfer    = req_r & imem.ack;
    assign consume     = if_valid_o & ~stall_i;
    assign out_free    = ~if_valid_o | consume;
    assign target_word = branch_target_address_i & 32'hFFFF_FFFC;

    // Address that follows a completed fetch: a same-edge redirect wins over
    // an older pending one, otherwise sequential (wraps modulo 2^32).
    always_comb begin
        pc_after_fetch = pc + 32'd4;
        if (branch_flag_i) begin
            pc_after_fetch = target_word;
        end else if (pend_valid) begin
            pc_after_fetch = pend_target;
        end
    end

    // Fetch FSM with PC, redirect, output-buffer and skid-buffer updates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            req_r       <= 1'b0;
            pc          <= RESET_PC_WORD;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            skid_pc     <= 32'd0;
            skid_inst   <= 32'd0;
            if_valid_o  <= 1'b0;
            if_pc_o     <= 32'd0;
            if_inst_o   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Nothing has been fetched yet, so a redirect here simply
                    // becomes the first fetch address.
                    if (branch_flag_i) begin
                        pc <= target_word;
                    end
                    state <= S_FETCH;
                    req_r <= 1'b1;
                end

                S_FETCH: begin
                    if (transfer) begin
                        pc         <= pc_after_fetch;
                        pend_valid <= 1'b0;
                        if (out_free) begin
                            if_valid_o <= 1'b1;
                            if_pc_o    <= pc;
                            if_inst_o  <= imem.rdata;
                        end else begin
                            skid_pc   <= pc;
                            skid_inst <= imem.rdata;
                            state     <= S_SKID;
                            req_r     <= 1'b0;
                        end
                    end else begin
                        // The outstanding fetch is the delay slot; remember the
                        // target and apply it once that fetch completes.
                        if (branch_flag_i) begin
                            pend_valid  <= 1'b1;
                            pend_target <= target_word;
                        end
                        if (consume) begin
                            if_valid_o <= 1'b0;
                        end
                    end
                end

                S_SKID: begin
                    // pc already points past the delay slot and no request is
                    // up, so a redirect can overwrite it directly.
                    if (branch_flag_i) begin
                        pc <= target_word;
                    end
                    if (consume) begin
                        if_pc_o   <= skid_pc;
                        if_inst_o <= skid_inst;
                        state     <= S_FETCH;
                        req_r     <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: a responding instruction memory with
// configurable/random latency, directed scenarios plus randomized stall,
// redirect and stray-ack traffic, checked every cycle against a queue model.
module tb_pc_fetch;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [31:0] tgt;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    pc_fetch_if imem();

    pc_fetch #(.RESET_PC(RESET_PC)) u_dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_i                 (stall),
        .branch_flag_i           (branch),
        .branch_target_address_i (tgt),
        .imem                    (imem),
        .if_valid_o              (if_valid),
        .if_pc_o                 (if_pc),
        .if_inst_o               (if_inst)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    assign imem.rdata = mem_word(imem.addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // Holds the instructions delivered but not yet consumed (at most output
    // plus skid), the next address to be requested, and a pending redirect.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_push;
    ent_t        m_drop;
    logic [31:0] m_next;
    logic [31:0] m_ptgt;
    bit          m_pend;
    bit          m_started;
    bit          mv_req;
    bit          mv_xfer;
    bit          mv_cons;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_next    = RESET_PC;
            m_ptgt    = 32'd0;
            m_pend    = 1'b0;
            m_started = 1'b0;
        end else begin
            mv_req  = m_started && (m_q.size() < 2);
            mv_xfer = mv_req && imem.ack;
            mv_cons = (m_q.size() > 0) && !stall;
            if (mv_cons) m_drop = m_q.pop_front();
            if (mv_xfer) begin
                m_push.pc   = m_next;
                m_push.inst = mem_word(m_next);
                m_q.push_back(m_push);
                if (branch)      m_next = tgt & 32'hFFFF_FFFC;
                else if (m_pend) m_next = m_ptgt;
                else             m_next = m_next + 32'd4;
                m_pend = 1'b0;
            end else if (branch) begin
                if (mv_req) begin
                    m_pend = 1'b1;
                    m_ptgt = tgt & 32'hFFFF_FFFC;
                end else begin
                    m_next = tgt & 32'hFFFF_FFFC;
                end
            end
            m_started = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          tmo_count = 0;
    int          tmo_seen = 0;
    bit          lit_addr_en = 0;
    logic [31:0] lit_addr_v = 0;
    bit          lit_pc_en = 0;
    logic [31:0] lit_pc_v = 0;
    bit          lit_req_en = 0;
    bit          lit_req_v = 0;
    bit          exp_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req",   {31'b0, imem.req}, 32'd0);
            chk("rst_addr",  imem.addr, RESET_PC);
            chk("rst_valid", {31'b0, if_valid}, 32'd0);
            chk("rst_pc",    if_pc, 32'd0);
            chk("rst_inst",  if_inst, 32'd0);
        end else begin
            exp_req = m_started && (m_q.size() < 2);
            chk("req", {31'b0, imem.req}, {31'b0, exp_req});
            if (exp_req) chk("addr", imem.addr, m_next);
            chk("valid", {31'b0, if_valid}, {31'b0, (m_q.size() > 0)});
            if (m_q.size() > 0) begin
                chk("if_pc",   if_pc,   m_q[0].pc);
                chk("if_inst", if_inst, m_q[0].inst);
            end
        end
        if (lit_addr_en) chk("lit_addr", imem.addr, lit_addr_v);
        if (lit_req_en)  chk("lit_req", {31'b0, imem.req}, {31'b0, lit_req_v});
        if (lit_pc_en) begin
            chk("lit_valid", {31'b0, if_valid}, 32'd1);
            chk("lit_if_pc", if_pc, lit_pc_v);
        end
        chk("wait_budget", tmo_count, tmo_seen);
        tmo_seen = tmo_count;
    end

    // ---------------- memory responder and stimulus ----------------
    int mem_fixed = 0;   // <0: random 0..3 wait cycles per fetch
    bit junk_ack  = 0;   // ack value driven while no request is up
    bit busy      = 0;
    bit ack_q     = 0;
    int dly       = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        lit_addr_en = 0;
        lit_pc_en   = 0;
        lit_req_en  = 0;
        if (ack_q) busy = 0;
        if (imem.req) begin
            if (!busy) begin
                busy = 1;
                dly  = (mem_fixed < 0) ? int'($urandom_range(0, 3)) : mem_fixed;
            end
            if (dly == 0) begin
                imem.ack = 1'b1;
            end else begin
                imem.ack = 1'b0;
                dly--;
            end
        end else begin
            busy     = 0;
            imem.ack = junk_ack;
        end
        ack_q = imem.ack && imem.req;
    endtask

    task automatic wait_addr(input logic [31:0] a, input bit want_eq);
        bit hit;
        hit = 0;
        for (int n = 0; n < 60 && !hit; n++) begin
            tick();
            hit = imem.req && ((imem.addr == a) == want_eq);
        end
        if (!hit) tmo_count++;
    endtask

    task automatic expect_addr(input logic [31:0] a);
        lit_addr_en = 1;
        lit_addr_v  = a;
        lit_req_en  = 1;
        lit_req_v   = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        imem.ack = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        tgt      = 32'd0;
        rst      = 1'b1;
        #1 rst   = 1'b0;

        // reset held, then release; zero-wait memory, no stall
        repeat (3) tick();
        rst = 1'b1;
        tick();
        expect_addr(32'hBFC0_0000);
        tick();
        expect_addr(32'hBFC0_0004);
        lit_pc_en = 1; lit_pc_v = 32'hBFC0_0000;
        tick();
        expect_addr(32'hBFC0_0008);
        lit_pc_en = 1; lit_pc_v = 32'hBFC0_0004;
        repeat (20) tick();

        // three wait cycles per fetch
        mem_fixed = 3;
        repeat (30) tick();

        // redirect while the delay slot (0x104) is outstanding
        tick(); branch = 1; tgt = 32'h0000_0100;
        tick(); branch = 0;
        wait_addr(32'h0000_0104, 1'b1);
        branch = 1; tgt = 32'h0000_0200;
        tick(); branch = 0;
        wait_addr(32'h0000_0104, 1'b0);
        expect_addr(32'h0000_0200);

        // redirect coinciding with the delay-slot ack
        tick(); branch = 1; tgt = 32'h0000_0100;
        tick(); branch = 0;
        hit = 0;
        for (int n = 0; n < 60 && !hit; n++) begin
            tick();
            hit = imem.req && (imem.addr == 32'h0000_0104) && imem.ack;
        end
        if (!hit) tmo_count++;
        branch = 1; tgt = 32'h0000_0200;
        tick(); branch = 0;
        expect_addr(32'h0000_0200);
        repeat (8) tick();

        // stall with output full while a zero-wait ack lands -> skid
        mem_fixed = 0;
        repeat (4) tick();
        stall = 1;
        tick();
        lit_req_en = 1; lit_req_v = 0;
        repeat (2) tick();
        stall = 0;
        repeat (6) tick();

        // PC wrap
        mem_fixed = 1;
        tick(); branch = 1; tgt = 32'hFFFF_FFF8;
        tick(); branch = 0;
        wait_addr(32'hFFFF_FFFC, 1'b1);
        wait_addr(32'hFFFF_FFFC, 1'b0);
        expect_addr(32'h0000_0000);
        repeat (4) tick();

        // randomized traffic
        mem_fixed = -1;
        repeat (600) begin
            tick();
            stall    = ($urandom_range(0, 99) < 30);
            branch   = ($urandom_range(0, 99) < 8);
            tgt      = $urandom;
            junk_ack = $urandom_range(0, 1) == 1;
        end
        tick();
        stall = 0; branch = 0; junk_ack = 0;
        repeat (6) tick();

        // reset while skid is full and a redirect was just taken, stray ack
        mem_fixed = 0;
        repeat (3) tick();
        stall = 1;
        repeat (2) tick();
        branch = 1; tgt = 32'h0000_0400;
        tick(); branch = 0;
        rst = 1'b0;
        junk_ack = 1;
        imem.ack = 1'b1;
        repeat (2) tick();
        stall = 0;
        mem_fixed = 3;
        rst = 1'b1;
        tick();
        junk_ack = 0;
        expect_addr(RESET_PC);
        repeat (20) tick();

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end of the five-stage MIPS pipeline. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and holds the fetched instruction for the IF/ID register. Consumes the decode stage's `branch_flag`/`branch_target_address` redirect (with MIPS delay-slot semantics) and the pipeline stall request. A one-entry skid buffer absorbs a fetch that completes while the pipeline is stalled.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset

- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = in reset)
- `stall_i`  in  1  IF/ID must hold; fetched instruction is not consumed this cycle
- `branch_flag_i`  in  1  decode stage requests a redirect
- `branch_target_address_i`  in  32  redirect target, valid with `branch_flag_i`
- `imem_req_o`  out  1  fetch request
- `imem_addr_o`  out  32  fetch word address, bits [1:0] forced to 0
- `imem_ack_i`  in  1  fetch complete this cycle; `imem_rdata_i` valid
- `imem_rdata_i`  in  32  fetched instruction word
- `if_valid_o`  out  1  `if_pc_o`/`if_inst_o` hold a valid instruction
- `if_pc_o`  out  32  address of the held instruction
- `if_inst_o`  out  32  held instruction word

## Operation
- Registers: `pc`, output buffer (`if_pc_o`, `if_inst_o`, `if_valid_o`), skid buffer (pc, inst), `pend_valid`, `pend_target`.
- Consume event: rising edge with `if_valid_o`=1 and `stall_i`=0.
- Transfer event: rising edge with `imem_req_o`=1 and `imem_ack_i`=1. An ack without a request is ignored.
- FSM states:
  - IDLE: the reset state. `imem_req_o`=0. Goes to FETCH unconditionally on the next edge.
  - FETCH: `imem_req_o`=1 and `imem_addr_o`=`pc`. Both stay stable until the transfer event. On transfer:
    - If the output buffer is empty or consumed this edge, the data loads into the output buffer and the state stays FETCH (back-to-back).
    - Otherwise the data loads into the skid buffer and the state goes to SKID.
    - In both cases `pc` advances: to `pend_target` if `pend_valid` (and `pend_valid` clears), else to `pc`+4.
  - SKID: `imem_req_o`=0. On a consume event the skid buffer moves to the output buffer (`if_valid_o` stays 1) and the state goes to FETCH.
- A consume event with no concurrent refill clears `if_valid_o`.
- Redirect: on any edge with `branch_flag_i`=1, `pend_valid`←1 and `pend_target`←target (a repeat overwrites). The fetch in flight or already transferred at that edge is the delay slot and is delivered normally. The redirect applies to the next fetch address.
  - If `branch_flag_i` coincides with a transfer, `pc` takes the new target directly and `pend_valid` stays 0.
  - If `pc` has already advanced to `pc`+4 past the delay slot in IDLE/SKID, the pending target replaces `pc` before the next request is raised.
- Arithmetic: `pc`+4 is modulo 2^32 (0xFFFF_FFFC → 0x0000_0000). The low two bits of the target are dropped.
- Ordering: instructions leave in fetch order, each exactly once. There is no drop and no duplicate.

## Timing
- Reset (`rst`=0, immediate, asynchronous):
  - `imem_req_o`=0 and `imem_addr_o`=`RESET_PC`.
  - `if_valid_o`=0, `if_pc_o`=0, `if_inst_o`=0.
  - `pc`=`RESET_PC`, `pend_valid`=0, state IDLE.
- First request: `imem_req_o` rises after the first clock edge following `rst` release.
- Latency: data sampled at the transfer edge appears on `if_*_o` right after that edge (0 extra cycles).
- Zero-wait memory (ack in the same cycle as req) with no stall gives one instruction per cycle.
- Memory must tolerate `imem_req_o` dropping without an ack (reset mid-fetch). An ack arriving after reset is ignored.
- Reset during SKID or with a pending redirect discards all buffered state.

## Test plan
- Reset release, zero-wait memory, `stall_i`=0 → addresses BFC00000, BFC00004, BFC00008 on consecutive cycles; `if_valid_o` is 1 from the cycle after the first ack, and `if_pc_o` tracks those addresses.
- Ack delayed 3 cycles per fetch → `imem_req_o`/`imem_addr_o` stay stable across the wait; `if_valid_o` is 1 for one cycle per fetch; no duplicate PCs.
- Branch at 0x100 in decode while 0x104 is outstanding, `branch_flag_i` pulsed with target 0x200 → 0x104 is delivered, then the next request address is 0x200. Repeat with the flag coinciding with the ack → same sequence.
- `stall_i` held 3 cycles while the output buffer is full and an ack arrives → state SKID, `imem_req_o`=0. On release, the two instructions are delivered on consecutive consume edges in order.
- `pc`=0xFFFF_FFFC fetched → next request address is 0x0000_0000.
- Assert `rst`=0 mid-wait with a pending redirect and a full skid buffer → all outputs take reset values immediately; after release the first fetch is `RESET_PC` and the late ack is ignored.
